// File: rtl/yuv_to_rgb.sv
// BT.601 full-range YCbCr 4:4:4 to RGB888 converter; control bits ride alongside. Optional BLANK_ZERO_EN forces black when delayed DE=0.
// Latency: 4 enabled clocks, one pixel per enabled clock.
// Backpressure: en=0 stalls every stage including outputs; no internal buffering.
module yuv_to_rgb #(
    parameter int LATENCY = 4,
    parameter int FRAC    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] in_y,
    input  logic [7:0] in_u,
    input  logic [7:0] in_v,
    input  logic [2:0] in_c,
    output logic [7:0] out_r,
    output logic [7:0] out_g,
    output logic [7:0] out_b,
    output logic [2:0] out_c
);

    generate
        if (LATENCY != 4 || FRAC != 8) begin : g_bad_param
            $error("yuv_to_rgb: only LATENCY=4 and FRAC=8 are supported");
        end
    endgenerate

    localparam logic signed [18:0] C_RV  = 19'sd359;
    localparam logic signed [18:0] C_GU  = 19'sd88;
    localparam logic signed [18:0] C_GV  = 19'sd183;
    localparam logic signed [18:0] C_BU  = 19'sd454;
    localparam logic signed [18:0] C_RND = 19'sd128;

    logic signed [8:0]  s1_y, s1_u, s1_v;
    logic        [2:0]  s1_c;
    logic signed [18:0] s2_y256, s2_rv, s2_gu, s2_gv, s2_bu;
    logic        [2:0]  s2_c;
    logic signed [18:0] s3_r, s3_g, s3_b;
    logic        [2:0]  s3_c;

    // Sum is in 1/256 units; drop the fraction and saturate to 0..255.
    function automatic logic [7:0] clamp8(input logic signed [18:0] s);
        logic [7:0] res;
        if (s[18])
            res = 8'd0;
        else if (|s[17:16])
            res = 8'hFF;
        else
            res = s[15:8];
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_y    <= '0;
            s1_u    <= '0;
            s1_v    <= '0;
            s1_c    <= '0;
            s2_y256 <= '0;
            s2_rv   <= '0;
            s2_gu   <= '0;
            s2_gv   <= '0;
            s2_bu   <= '0;
            s2_c    <= '0;
            s3_r    <= '0;
            s3_g    <= '0;
            s3_b    <= '0;
            s3_c    <= '0;
            out_r   <= '0;
            out_g   <= '0;
            out_b   <= '0;
            out_c   <= '0;
        end else if (en) begin
            s1_y    <= $signed({1'b0, in_y});
            s1_u    <= $signed({1'b0, in_u}) - 9'sd128;
            s1_v    <= $signed({1'b0, in_v}) - 9'sd128;
            s1_c    <= in_c;

            s2_y256 <= 19'(s1_y) <<< 8;
            s2_rv   <= 19'(s1_v) * C_RV;
            s2_gu   <= 19'(s1_u) * C_GU;
            s2_gv   <= 19'(s1_v) * C_GV;
            s2_bu   <= 19'(s1_u) * C_BU;
            s2_c    <= s1_c;

            s3_r    <= s2_y256 + s2_rv + C_RND;
            s3_g    <= s2_y256 - s2_gu - s2_gv + C_RND;
            s3_b    <= s2_y256 + s2_bu + C_RND;
            s3_c    <= s2_c;

`ifdef BLANK_ZERO_EN
            if (!s3_c[2]) begin
                out_r <= '0;
                out_g <= '0;
                out_b <= '0;
            end else begin
                out_r <= clamp8(s3_r);
                out_g <= clamp8(s3_g);
                out_b <= clamp8(s3_b);
            end
`else
            out_r   <= clamp8(s3_r);
            out_g   <= clamp8(s3_g);
            out_b   <= clamp8(s3_b);
`endif
            out_c   <= s3_c;
        end
    end

endmodule

// File: tb/tb_yuv_to_rgb.sv
// Scoreboard bench for yuv_to_rgb: stimulus pushes hand-computed results, a monitor pops them as pixels emerge.
module tb_yuv_to_rgb;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] in_y, in_u, in_v;
    logic [2:0] in_c;
    logic [7:0] out_r, out_g, out_b;
    logic [2:0] out_c;
    logic       issue;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [2:0] c;
    } exp_t;

    exp_t sb[$];

    // Directed pixels with hand-computed BT.601 results.
    logic [7:0] vy [0:8] = '{8'd128, 8'd81,  8'd255, 8'd0,   8'd0,   8'd255, 8'd100, 8'd50,  8'd200};
    logic [7:0] vu [0:8] = '{8'd128, 8'd90,  8'd255, 8'd128, 8'd128, 8'd128, 8'd0,   8'd128, 8'd60};
    logic [7:0] vv [0:8] = '{8'd128, 8'd240, 8'd128, 8'd255, 8'd128, 8'd128, 8'd128, 8'd0,   8'd180};
    logic [7:0] er [0:8] = '{8'd128, 8'd238, 8'd255, 8'd178, 8'd0,   8'd255, 8'd100, 8'd0,   8'd255};
    logic [7:0] eg [0:8] = '{8'd128, 8'd14,  8'd211, 8'd0,   8'd0,   8'd255, 8'd144, 8'd142, 8'd186};
    logic [7:0] eb [0:8] = '{8'd128, 8'd14,  8'd255, 8'd0,   8'd0,   8'd255, 8'd0,   8'd50,  8'd79};

    yuv_to_rgb dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .in_y  (in_y),
        .in_u  (in_u),
        .in_v  (in_v),
        .in_c  (in_c),
        .out_r (out_r),
        .out_g (out_g),
        .out_b (out_b),
        .out_c (out_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [26:0] act, input logic [26:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got r=%0d g=%0d b=%0d c=%b, expected r=%0d g=%0d b=%0d c=%b",
                     name, act[26:19], act[18:11], act[10:3], act[2:0],
                     req[26:19], req[18:11], req[10:3], req[2:0]);
        end
    endtask

    // One clock of stimulus; a pixel is issued only on enabled cycles.
    task automatic step(input logic e, input logic iss, input int idx, input logic [2:0] c);
        exp_t x;
        en    = e;
        issue = iss;
        if (iss) begin
            in_y = vy[idx];
            in_u = vu[idx];
            in_v = vv[idx];
            in_c = c;
            x.r = er[idx];
            x.g = eg[idx];
            x.b = eb[idx];
            x.c = c;
`ifdef BLANK_ZERO_EN
            if (!c[2]) begin
                x.r = 8'd0;
                x.g = 8'd0;
                x.b = 8'd0;
            end
`endif
            sb.push_back(x);
        end else begin
            in_y = 8'hA5;
            in_u = 8'h3C;
            in_v = 8'hE1;
            in_c = 3'b011;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: latency tags track what each output slot should hold.
    localparam logic [1:0] T_NONE = 2'd0, T_ZERO = 2'd1, T_PIX = 2'd2;
    initial begin
        logic [1:0]  tag [0:3];
        logic        s_rst, s_en, s_iss;
        logic [26:0] prev;
        exp_t        x;
        for (int k = 0; k < 4; k++) tag[k] = T_NONE;
        prev = '0;
        forever begin
            @(posedge clk);
            s_rst = rst;
            s_en  = en;
            s_iss = issue;
            if (s_rst) begin
                for (int k = 0; k < 4; k++) begin
                    if (tag[k] == T_PIX && sb.size() > 0) void'(sb.pop_front());
                    tag[k] = T_ZERO;
                end
            end else if (s_en) begin
                tag[3] = tag[2];
                tag[2] = tag[1];
                tag[1] = tag[0];
                tag[0] = s_iss ? T_PIX : T_NONE;
            end
            @(negedge clk);
            if (s_rst || s_en) begin
                if (tag[3] == T_ZERO) begin
                    chk("zero_after_reset", {out_r, out_g, out_b, out_c}, 27'd0);
                end else if (tag[3] == T_PIX) begin
                    if (sb.size() == 0) begin
                        chk("scoreboard_underflow", {out_r, out_g, out_b, out_c}, ~27'd0);
                    end else begin
                        x = sb.pop_front();
                        chk("pixel", {out_r, out_g, out_b, out_c}, x);
                    end
                end
            end else if (!s_rst) begin
                chk("hold_when_stalled", {out_r, out_g, out_b, out_c}, prev);
            end
            prev = {out_r, out_g, out_b, out_c};
        end
    end

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        issue = 1'b0;
        in_y  = '0;
        in_u  = '0;
        in_v  = '0;
        in_c  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Mid-grey first, then idle enabled cycles so it drains behind zeros.
        step(1'b1, 1'b1, 0, 3'b100);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 3'b000);

        // Continuous streaming across the full vector table.
        for (int i = 1; i < 9; i++) step(1'b1, 1'b1, i, {1'b1, 2'(i)});

        // Same pixels with en toggling; results must match the streaming run.
        for (int i = 1; i < 9; i++) begin
            step(1'b1, 1'b1, i, {1'b1, 2'(i + 1)});
            step(1'b0, 1'b0, 0, 3'b000);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 0, 3'b000);
            step(1'b0, 1'b0, 0, 3'b000);
        end

        // Reset mid-stream with en high: in-flight pixels must vanish.
        step(1'b1, 1'b1, 2, 3'b101);
        step(1'b1, 1'b1, 3, 3'b110);
        step(1'b1, 1'b1, 6, 3'b111);
        rst = 1'b1;
        step(1'b1, 1'b0, 0, 3'b000);
        rst = 1'b0;
        step(1'b1, 1'b1, 7, 3'b100);
        step(1'b1, 1'b1, 1, 3'b110);

        // Blanking: white pixel with DE low and high.
        step(1'b1, 1'b1, 5, 3'b000);
        step(1'b1, 1'b1, 5, 3'b100);
        step(1'b1, 1'b1, 5, 3'b011);

        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0, 3'b000);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pixels never emerged, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
